noc_injector: RTL and testbench

- Source-side network interface for the mesh node: the transmit counterpart of the ejector/route-select stage.
- Accepts a packet request from the local processing element: a 6-bit destination (row [5:3], col [2:0]) plus 1-8 payload bytes.
- Serialises the packet into 10-bit flits (HEAD, BODY..., TAIL) and drives them into the router local input port under a valid/ready handshake.
- Buffers payload bytes in a small FIFO so the PE can stream data ahead of the flit stream.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/noc_inj_fifo.sv | 47 ++++
 rtl/noc_injector.sv | 121 ++++++++++++
 tb/tb_noc_injector.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit, address and direction definitions for the mesh NoC
package noc_pkg;

    localparam int FLIT_W = 10;
    localparam int ADDR_W = 6;

    typedef enum logic [1:0] {
        FLIT_NONE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_BODY = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        DIR_EAST  = 3'b000,
        DIR_WEST  = 3'b001,
        DIR_NORTH = 3'b010,
        DIR_SOUTH = 3'b011,
        DIR_LOCAL = 3'b100
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_PAYLOAD,
        ST_DROP
    } inj_state_e;

    function automatic logic [FLIT_W-1:0] mk_flit(input flit_type_e t, input logic [7:0] p);
        return {t, p};
    endfunction

endpackage

// File: rtl/noc_inj_fifo.sv
// noc_inj_fifo: synchronous 8-bit payload FIFO with full/empty flags.
// Ports: clk, rst (sync, active-high); push/din write side (ignored when full);
//        pop/dout read side (dout shows the head entry, ignored when empty); full, empty.
module noc_inj_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/noc_injector.sv
// noc_injector: serialises PE packet requests into HEAD/BODY/TAIL flits for the router local port.
// Ports: clk, rst (sync, active-high);
//        req_valid/req_ready/req_dest/req_len  packet request (len = payload flits - 1);
//        data_valid/data_ready/data            payload byte stream into the FIFO;
//        flit_valid/flit_ready/flit_out        flit stream to the router;
//        pkt_sent                              count of accepted TAIL flits (wraps).
// Build option: define NOC_INJ_SELF_DROP_EN to silently drain packets addressed to LOCAL_ADDR.
import noc_pkg::*;

module noc_injector #(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] LOCAL_ADDR = 6'b100100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_dest,
    input  logic [2:0]        req_len,
    output logic              req_ready,
    input  logic              data_valid,
    input  logic [7:0]        data,
    output logic              data_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              flit_ready,
    output logic [7:0]        pkt_sent
);

`ifdef NOC_INJ_SELF_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    inj_state_e        state;
    logic [ADDR_W-1:0] dest_q;
    logic [2:0]        rem;
    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic              pop, tail_in_reg;
    flit_type_e        next_type;

    noc_inj_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_valid),
        .din   (data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign req_ready   = state == ST_IDLE;
    assign data_ready  = !fifo_full;
    assign tail_in_reg = flit_valid && flit_out[9:8] == FLIT_TAIL;
    assign next_type   = rem == 3'd0 ? FLIT_TAIL : FLIT_BODY;

    // Popping during the HEAD handshake keeps the flit stream back-to-back;
    // once the TAIL sits in the output register the next packet's bytes stay put.
    always_comb begin
        pop = !fifo_empty && (state == ST_HEAD    ? flit_valid && flit_ready :
                              state == ST_PAYLOAD ? (!flit_valid || flit_ready) && !tail_in_reg :
                              state == ST_DROP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dest_q     <= '0;
            rem        <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            pkt_sent   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        dest_q <= req_dest;
                        rem    <= req_len;
                        state  <= (DROP_EN && req_dest == LOCAL_ADDR) ? ST_DROP : ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (!flit_valid) begin
                        flit_out   <= mk_flit(FLIT_HEAD, {2'b00, dest_q});
                        flit_valid <= 1'b1;
                    end else if (flit_ready) begin
                        state      <= ST_PAYLOAD;
                        flit_valid <= pop;
                        if (pop) begin
                            flit_out <= mk_flit(next_type, fifo_dout);
                            rem      <= rem - 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (pop) begin
                        flit_out   <= mk_flit(next_type, fifo_dout);
                        flit_valid <= 1'b1;
                        rem        <= rem - 1'b1;
                    end else if (flit_ready) begin
                        flit_valid <= 1'b0;
                    end
                    if (tail_in_reg && flit_ready) begin
                        state    <= ST_IDLE;
                        pkt_sent <= pkt_sent + 1'b1;
                    end
                end
                ST_DROP: begin
                    if (pop) begin
                        rem <= rem - 1'b1;
                        if (rem == 3'd0) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_injector.sv
// tb_noc_injector: directed checks of flit serialisation, stalls, FIFO full and reset abort
module tb_noc_injector;

    logic       clk = 1'b0;
    logic       rst, req_valid, data_valid, flit_ready;
    logic [5:0] req_dest;
    logic [2:0] req_len;
    logic [7:0] data;
    logic       req_ready, data_ready, flit_valid;
    logic [9:0] flit_out;
    logic [7:0] pkt_sent;
    int         n_chk = 0;
    int         n_err = 0;

    noc_injector dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .data_valid (data_valid),
        .data       (data),
        .data_ready (data_ready),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .pkt_sent   (pkt_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        data_valid = 1'b1;
        data       = b;
        tick;
        data_valid = 1'b0;
    endtask

    task automatic req(input logic [5:0] d, input logic [2:0] l);
        req_valid = 1'b1;
        req_dest  = d;
        req_len   = l;
        tick;
        req_valid = 1'b0;
    endtask

    task automatic exp_flit(input string tag, input logic [9:0] v);
        chk({tag, "_v"}, 16'(flit_valid), 16'd1);
        chk(tag, 16'(flit_out), 16'(v));
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; data_valid = 1'b0; flit_ready = 1'b1;
        req_dest = '0; req_len = '0; data = '0;
        tick; tick;
        rst = 1'b0;
        chk("rst_fv", 16'(flit_valid), 16'd0);
        chk("rst_fo", 16'(flit_out), 16'd0);
        chk("rst_ps", 16'(pkt_sent), 16'd0);
        chk("rst_rr", 16'(req_ready), 16'd1);
        chk("rst_dr", 16'(data_ready), 16'd1);

        // basic packet, full throughput
        push(8'hA1); push(8'hB2); push(8'hC3);
        req(6'b011101, 3'd2);
        chk("t1_rr_busy", 16'(req_ready), 16'd0);
        chk("t1_lat", 16'(flit_valid), 16'd0);
        tick;
        exp_flit("t1_head", 10'h11D);
        exp_flit("t1_b0", 10'h2A1);
        exp_flit("t1_b1", 10'h2B2);
        exp_flit("t1_tail", 10'h3C3);
        chk("t1_fv_end", 16'(flit_valid), 16'd0);
        chk("t1_ps", 16'(pkt_sent), 16'd1);
        chk("t1_rr", 16'(req_ready), 16'd1);

        // stall during first BODY flit
        push(8'hA1); push(8'hB2); push(8'hC3);
        req(6'b011101, 3'd2);
        tick;
        exp_flit("t2_head", 10'h11D);
        chk("t2_b0", 16'(flit_out), 16'h2A1);
        flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2_hold_v", 16'(flit_valid), 16'd1);
            chk("t2_hold", 16'(flit_out), 16'h2A1);
        end
        flit_ready = 1'b1;
        tick;
        exp_flit("t2_b1", 10'h2B2);
        exp_flit("t2_tail", 10'h3C3);
        chk("t2_fv_end", 16'(flit_valid), 16'd0);
        chk("t2_ps", 16'(pkt_sent), 16'd2);

        // single-byte packet
        push(8'h5F);
        req(6'b000001, 3'd0);
        tick;
        exp_flit("t3_head", 10'h101);
        chk("t3_tail_v", 16'(flit_valid), 16'd1);
        chk("t3_tail", 16'(flit_out), 16'h35F);
        chk("t3_rr_busy", 16'(req_ready), 16'd0);
        tick;
        chk("t3_rr", 16'(req_ready), 16'd1);
        chk("t3_fv_end", 16'(flit_valid), 16'd0);
        chk("t3_ps", 16'(pkt_sent), 16'd3);

        // FIFO full; fifth byte must be refused
        push(8'h11); push(8'h22); push(8'h33);
        chk("t4_dr3", 16'(data_ready), 16'd1);
        push(8'h44);
        chk("t4_full", 16'(data_ready), 16'd0);
        data_valid = 1'b1; data = 8'hEE;
        tick;
        data_valid = 1'b0;
        chk("t4_full2", 16'(data_ready), 16'd0);
        req(6'b000000, 3'd3);
        tick;
        exp_flit("t4_head", 10'h100);
        exp_flit("t4_b0", 10'h211);
        exp_flit("t4_b1", 10'h222);
        exp_flit("t4_b2", 10'h233);
        exp_flit("t4_tail", 10'h344);
        chk("t4_fv_end", 16'(flit_valid), 16'd0);
        chk("t4_ps", 16'(pkt_sent), 16'd4);
        chk("t4_dr", 16'(data_ready), 16'd1);
        push(8'h55);
        req(6'b000010, 3'd0);
        tick;
        exp_flit("t4_head2", 10'h102);
        exp_flit("t4_tail2", 10'h355);
        chk("t4_ps2", 16'(pkt_sent), 16'd5);

        // reset mid-packet after HEAD handshake
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        req(6'b010010, 3'd7);
        tick;
        exp_flit("t5_head", 10'h112);
        chk("t5_b0", 16'(flit_out), 16'h291);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_fv", 16'(flit_valid), 16'd0);
        chk("t5_fo", 16'(flit_out), 16'd0);
        chk("t5_rr", 16'(req_ready), 16'd1);
        chk("t5_dr", 16'(data_ready), 16'd1);
        chk("t5_ps", 16'(pkt_sent), 16'd0);
        tick;
        chk("t5_fv2", 16'(flit_valid), 16'd0);
        push(8'h66);
        req(6'b000011, 3'd0);
        tick;
        exp_flit("t5_head2", 10'h103);
        exp_flit("t5_tail2", 10'h366);
        chk("t5_ps2", 16'(pkt_sent), 16'd1);

        // self-addressed packet
        push(8'h01); push(8'h02);
        req(6'b100100, 3'd1);
`ifdef NOC_INJ_SELF_DROP_EN
        for (int i = 0; i < 4; i++) begin
            chk("t6_drop_v", 16'(flit_valid), 16'd0);
            tick;
        end
        chk("t6_rr", 16'(req_ready), 16'd1);
        chk("t6_ps", 16'(pkt_sent), 16'd1);
        push(8'h77);
        req(6'b000101, 3'd0);
        tick;
        exp_flit("t6_head2", 10'h105);
        exp_flit("t6_tail2", 10'h377);
        chk("t6_ps2", 16'(pkt_sent), 16'd2);
`else
        tick;
        exp_flit("t6_head", 10'h124);
        exp_flit("t6_b0", 10'h201);
        exp_flit("t6_tail", 10'h302);
        chk("t6_fv_end", 16'(flit_valid), 16'd0);
        chk("t6_ps", 16'(pkt_sent), 16'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
